btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Button conditioner for the board push-buttons. It synchronises the raw,
//   bouncing btn pin and debounces it with a stability counter. It then
//   delivers clean single-cycle press/release/auto-repeat events plus a level.
//   It sits between the btn pin and the colour-stepping rgb logic, which
//   consumes btn_press/btn_repeat as "advance one colour" strobes.
// PARAMETERS
//   DEBOUNCE_CYCLES  5_000_000   consecutive stable cycles required (50 ms @ 100 MHz)
//   REPEAT_EN        1           1 = auto-repeat while held; 0 = btn_repeat tied low
//   REPEAT_DELAY     50_000_000  cycles from btn_press to first btn_repeat (500 ms)
//   REPEAT_PERIOD    20_000_000  cycles between subsequent btn_repeat pulses (200 ms)
//   CNT_W            26          counter width; must hold max(all counts above)
// PORTS
//   clk          in   1  system clock, 100 MHz
//   nrst         in   1  asynchronous active-low reset
//   btn          in   1  raw asynchronous button pin, active-high, bouncing
//   btn_level    out  1  debounced level, 1 = held
//   btn_press    out  1  one-cycle strobe on debounced 0->1
//   btn_release  out  1  one-cycle strobe on debounced 1->0
//   btn_repeat   out  1  one-cycle auto-repeat strobe while held
// BEHAVIOUR
//   - Reset (nrst=0, async): sync FFs, counters and state cleared; state=IDLE.
//     All outputs 0. Release of reset is not itself an event.
//   - Input path: btn passes a 2-FF synchroniser -> btn_s. Only btn_s is used.
//   - FSM states:
//     - IDLE (level 0): btn_s=1 -> PRESS_WAIT, db_cnt=0.
//     - PRESS_WAIT: btn_s=0 -> IDLE (glitch dropped, no event).
//       Otherwise db_cnt++.
//       At db_cnt==DEBOUNCE_CYCLES-1 with btn_s=1 -> HELD: btn_press=1 for
//       that cycle, btn_level=1, rpt_cnt=0.
//     - HELD: btn_s=0 -> REL_WAIT, db_cnt=0. Otherwise rpt_cnt runs
//       (if REPEAT_EN).
//     - REL_WAIT: btn_s=1 -> HELD (bounce ignored; rpt_cnt keeps running).
//       At db_cnt==DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE: btn_release=1,
//       btn_level=0.
//   - Any btn_s change during a WAIT state restarts qualification.
//     An event therefore needs DEBOUNCE_CYCLES consecutive equal samples.
//   - Latency:
//     - btn_press is registered. It is high in the clock cycle
//       2+DEBOUNCE_CYCLES edges after the first edge that samples btn=1
//       and stays 1.
//     - btn_release uses the same latency, measured from the release edge.
//   - Auto-repeat (REPEAT_EN=1):
//     - btn_repeat pulses REPEAT_DELAY cycles after btn_press.
//     - It then pulses every REPEAT_PERIOD cycles while in HELD or REL_WAIT.
//     - rpt_cnt clears on entry to IDLE.
//     - A pending repeat in REL_WAIT still fires only if the release is
//       not yet confirmed.
//   - Exclusivity: btn_press/btn_release/btn_repeat are mutually exclusive
//     and never consecutive-cycle duplicates. btn_press never coincides
//     with btn_repeat.
//   - Counter wrap: counters saturate and never wrap. CNT_W too small is
//     a configuration error, checked by an elaboration assertion.
//   - btn held through reset: after nrst rises, state=IDLE sees btn_s=1.
//     A normal debounced btn_press follows. Exactly one press is reported.
//   - Reset mid-operation: forces IDLE immediately.
//     - No btn_release is emitted for a press cut off by reset.
//     - btn_level drops to 0 asynchronously.
// TESTING (sim params: DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=10)
//   1. nrst=0 with btn=1 toggling, then release nrst with btn=1 steady
//      -> all outputs 0 during reset; one btn_press 10 cycles after release.
//   2. Clean press: btn 0->1 held 15 cycles, then 0 held 15 cycles
//      -> btn_press at edge+10, btn_level 1 for exactly 15 cycles,
//         btn_release at fall+10.
//   3. Bounce: btn toggles every 3 cycles for 60 cycles, then steady 1
//      -> no strobes during bounce; single btn_press 10 cycles after last
//         edge.
//   4. Glitch: 1-cycle and 7-cycle btn highs while idle
//      -> no btn_press, btn_level stays 0.
//   5. Auto-repeat: btn held 60 cycles after btn_press
//      -> btn_repeat at press+20, +30, +40, +50; REPEAT_EN=0 -> none.
//   6. Reset mid-hold: nrst=0 pulse while btn_level=1
//      -> btn_level 0 immediately, no btn_release; re-press after debounce.

Source files
------------

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Conditions one raw push-button pin for the colour-stepping logic. The pin
//   goes through a two-flop synchroniser. A stability counter then qualifies
//   each change of the synchronised level. The block produces a clean level and
//   single-cycle press / release / auto-repeat strobes.
//
// Ports
//   clk          system clock
//   nrst         asynchronous active-low reset
//   btn          raw asynchronous button pin, active-high, may bounce
//   btn_level    debounced level, 1 while the button is held
//   btn_press    one-cycle strobe on a confirmed 0->1
//   btn_release  one-cycle strobe on a confirmed 1->0
//   btn_repeat   one-cycle auto-repeat strobe while held (tied low if
//                REPEAT_EN = 0)
// -----------------------------------------------------------------------------
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 5_000_000,
  parameter bit          REPEAT_EN       = 1'b1,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 20_000_000,
  parameter int unsigned CNT_W           = 26
) (
  input  logic clk,
  input  logic nrst,
  input  logic btn,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_repeat
);

  // ---------------------------------------------------------------------------
  // Configuration checks. These are evaluated at elaboration time. Each counter
  // only needs to reach (count - 1). Requiring the full count to fit keeps the
  // rule simple and leaves room for the saturation value.
  // ---------------------------------------------------------------------------
  localparam longint unsigned CNT_CAP  = (64'd1 << CNT_W) - 64'd1;
  localparam longint unsigned RPT_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                                         64'(REPEAT_DELAY) : 64'(REPEAT_PERIOD);
  localparam longint unsigned NEED_MAX = (REPEAT_EN && (RPT_MAX > 64'(DEBOUNCE_CYCLES))) ?
                                         RPT_MAX : 64'(DEBOUNCE_CYCLES);

  generate
    if (DEBOUNCE_CYCLES == 0 || (REPEAT_EN && (REPEAT_DELAY == 0 || REPEAT_PERIOD == 0)))
    begin : g_cfg_zero
      $error("btn_debounce: cycle counts must be non-zero");
    end
    if (CNT_W < 1 || CNT_W > 32 || NEED_MAX > CNT_CAP) begin : g_cfg_width
      $error("btn_debounce: CNT_W too small for the configured counts");
    end
  endgenerate

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_FIRST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RPT_NEXT  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  // ---------------------------------------------------------------------------
  // Input synchroniser. Only btn_s_reg is used past this point.
  // ---------------------------------------------------------------------------
  logic sync_meta_reg;
  logic btn_s_reg;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_meta_reg <= 1'b0;
      btn_s_reg     <= 1'b0;
    end else begin
      sync_meta_reg <= btn;
      btn_s_reg     <= sync_meta_reg;
    end
  end

  // ---------------------------------------------------------------------------
  // Debounce / repeat state machine
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_WAIT = 2'd1,
    HELD       = 2'd2,
    REL_WAIT   = 2'd3
  } state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] db_cnt_reg;
  logic [CNT_W-1:0] rpt_cnt_reg;
  logic             rpt_first_done_reg;  // first repeat issued; now on the period

  // The repeat counter measures cycles since the last press or repeat. When it
  // hits the current target it fires and restarts. The same step is applied in
  // HELD and in unconfirmed REL_WAIT, so a repeat can still fire while a
  // release is being qualified.
  logic [CNT_W-1:0] rpt_cnt_next;
  logic             rpt_first_done_next;
  logic             rpt_fire;
  logic [CNT_W-1:0] rpt_target;

  assign rpt_target = rpt_first_done_reg ? RPT_NEXT : RPT_FIRST;

  always_comb begin
    rpt_cnt_next        = rpt_cnt_reg;
    rpt_first_done_next = rpt_first_done_reg;
    rpt_fire            = 1'b0;
    if (REPEAT_EN) begin
      if (rpt_cnt_reg == rpt_target) begin
        rpt_cnt_next        = '0;
        rpt_first_done_next = 1'b1;
        rpt_fire            = 1'b1;
      end else if (rpt_cnt_reg != CNT_SAT) begin
        rpt_cnt_next = rpt_cnt_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg          <= IDLE;
      db_cnt_reg         <= '0;
      rpt_cnt_reg        <= '0;
      rpt_first_done_reg <= 1'b0;
      btn_level          <= 1'b0;
      btn_press          <= 1'b0;
      btn_release        <= 1'b0;
      btn_repeat         <= 1'b0;
    end else begin
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_repeat  <= 1'b0;

      case (state_reg)
        IDLE: begin
          if (btn_s_reg) begin
            state_reg  <= PRESS_WAIT;
            db_cnt_reg <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!btn_s_reg) begin
            state_reg <= IDLE;               // glitch: dropped silently
          end else if (db_cnt_reg == DB_LAST) begin
            state_reg          <= HELD;
            btn_press          <= 1'b1;
            btn_level          <= 1'b1;
            rpt_cnt_reg        <= '0;
            rpt_first_done_reg <= 1'b0;
          end else if (db_cnt_reg != CNT_SAT) begin
            db_cnt_reg <= db_cnt_reg + 1'b1;
          end
        end

        HELD: begin
          if (!btn_s_reg) begin
            state_reg  <= REL_WAIT;
            db_cnt_reg <= '0;
          end
          rpt_cnt_reg        <= rpt_cnt_next;
          rpt_first_done_reg <= rpt_first_done_next;
          btn_repeat         <= rpt_fire;
        end

        REL_WAIT: begin
          if (!btn_s_reg && db_cnt_reg == DB_LAST) begin
            // A confirmed release wins over a repeat due in the same cycle.
            state_reg          <= IDLE;
            btn_release        <= 1'b1;
            btn_level          <= 1'b0;
            rpt_cnt_reg        <= '0;
            rpt_first_done_reg <= 1'b0;
          end else begin
            if (btn_s_reg) begin
              state_reg <= HELD;             // bounce back: still held
            end else if (db_cnt_reg != CNT_SAT) begin
              db_cnt_reg <= db_cnt_reg + 1'b1;
            end
            rpt_cnt_reg        <= rpt_cnt_next;
            rpt_first_done_reg <= rpt_first_done_next;
            btn_repeat         <= rpt_fire;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_btn_debounce.sv
// -----------------------------------------------------------------------------
// tb_btn_debounce
//   Bench for btn_debounce. It uses small cycle counts and two instances: one
//   with auto-repeat and one without. A behavioural model derives the expected
//   outputs from the debounce rules:
//     - btn is seen two edges late.
//     - The level flips after DB+1 consecutive disagreeing samples.
//     - Repeats fire at RD, RD+RP, RD+2*RP, ... cycles after a press while the
//       level is still 1.
//   The model is checked every cycle. Directed scenarios also pin their
//   latencies with literal numbers.
// -----------------------------------------------------------------------------
module tb_btn_debounce;

  localparam int DB = 8;
  localparam int RD = 20;
  localparam int RP = 10;
  localparam int CW = 8;

  logic clk;
  logic nrst;
  logic btn;
  logic a_level, a_press, a_release, a_repeat;
  logic b_level, b_press, b_release, b_repeat;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b1), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut_a (
    .clk(clk), .nrst(nrst), .btn(btn),
    .btn_level(a_level), .btn_press(a_press),
    .btn_release(a_release), .btn_repeat(a_repeat)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_EN(1'b0), .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP), .CNT_W(CW)
  ) dut_b (
    .clk(clk), .nrst(nrst), .btn(btn),
    .btn_level(b_level), .btn_press(b_press),
    .btn_release(b_release), .btn_repeat(b_repeat)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model, advanced once per rising edge
  // ---------------------------------------------------------------------------
  bit [1:0] m_pipe;     // [0] = btn one edge ago, [1] = two edges ago
  bit       m_s;
  bit       m_level, m_press, m_release, m_repeat;
  int       m_run;      // consecutive samples disagreeing with the level
  int       m_k;        // cycles since the last press

  initial begin
    m_pipe = '0; m_level = 0; m_press = 0; m_release = 0; m_repeat = 0;
    m_run = 0; m_k = 0; m_s = 0;
    forever begin
      @(posedge clk);
      m_press = 0; m_release = 0; m_repeat = 0;
      if (!nrst) begin
        m_pipe = '0; m_level = 0; m_run = 0; m_k = 0;
      end else begin
        m_s    = m_pipe[1];
        m_pipe = {m_pipe[0], btn};
        m_run  = (m_s != m_level) ? m_run + 1 : 0;
        if (m_run == DB + 1) begin
          m_level = m_s;
          m_run   = 0;
          if (m_s) begin
            m_press = 1;
            m_k     = 0;
          end else begin
            m_release = 1;
          end
        end else if (m_level) begin
          m_k++;
          if (m_k == RD || (m_k > RD && ((m_k - RD) % RP) == 0)) m_repeat = 1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare (falling edge) and event statistics
  // ---------------------------------------------------------------------------
  int st_press_n, st_rel_n, st_rpt_n, st_b_rpt_n, st_level_hi;
  int st_press_cyc, st_rel_cyc;
  int st_rpt_cyc[8];

  task automatic clear_stats();
    st_press_n = 0; st_rel_n = 0; st_rpt_n = 0; st_b_rpt_n = 0; st_level_hi = 0;
    st_press_cyc = -1000; st_rel_cyc = -1000;
    for (int i = 0; i < 8; i++) st_rpt_cyc[i] = -1000;
  endtask

  initial begin
    clear_stats();
    forever begin
      @(negedge clk);
      chk_bit("a_level",   a_level,   nrst ? m_level   : 1'b0);
      chk_bit("a_press",   a_press,   nrst ? m_press   : 1'b0);
      chk_bit("a_release", a_release, nrst ? m_release : 1'b0);
      chk_bit("a_repeat",  a_repeat,  nrst ? m_repeat  : 1'b0);
      chk_bit("b_level",   b_level,   nrst ? m_level   : 1'b0);
      chk_bit("b_press",   b_press,   nrst ? m_press   : 1'b0);
      chk_bit("b_release", b_release, nrst ? m_release : 1'b0);
      chk_bit("b_repeat",  b_repeat,  1'b0);
      if (a_press) begin
        st_press_n++; st_press_cyc = cyc;
        $display("cyc=%0d event press", cyc);
      end
      if (a_release) begin
        st_rel_n++; st_rel_cyc = cyc;
        $display("cyc=%0d event release", cyc);
      end
      if (a_repeat) begin
        if (st_rpt_n < 8) st_rpt_cyc[st_rpt_n] = cyc;
        st_rpt_n++;
        $display("cyc=%0d event repeat", cyc);
      end
      if (b_repeat) st_b_rpt_n++;
      if (a_level) st_level_hi++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change 3 time units after each rising edge
  // ---------------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  int c0, c1;

  initial begin
    nrst = 1'b0;
    btn  = 1'b0;
    tick(1);

    // 1: button bouncing through reset, then held steady as reset lifts
    for (int i = 0; i < 10; i++) begin
      btn = ~btn;
      tick(1);
    end
    clear_stats();
    btn = 1'b1; nrst = 1'b1; c0 = cyc;
    tick(20);
    chk_int("t1_press_count", st_press_n, 1);
    chk_int("t1_press_latency", st_press_cyc - c0, DB + 3);
    btn = 1'b0;
    tick(20);

    // 2: clean press and release
    clear_stats();
    btn = 1'b1; c0 = cyc;
    tick(15);
    btn = 1'b0; c1 = cyc;
    tick(15);
    chk_int("t2_press_latency", st_press_cyc - c0, 11);
    chk_int("t2_release_latency", st_rel_cyc - c1, 11);
    chk_int("t2_level_cycles", st_level_hi, 15);
    chk_int("t2_release_count", st_rel_n, 1);

    // 3: bounce every 3 cycles, then steady high
    clear_stats();
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      tick(3);
    end
    btn = 1'b1; c0 = cyc;
    tick(20);
    chk_int("t3_press_count", st_press_n, 1);
    chk_int("t3_press_latency", st_press_cyc - c0, 11);
    btn = 1'b0;
    tick(20);

    // 4: short glitches while idle
    clear_stats();
    btn = 1'b1; tick(1);
    btn = 1'b0; tick(12);
    btn = 1'b1; tick(7);
    btn = 1'b0; tick(15);
    chk_int("t4_press_count", st_press_n, 0);
    chk_int("t4_level_cycles", st_level_hi, 0);

    // 5: auto-repeat; the release starts 45 cycles after the press, so the
    //    +50 repeat lands during release qualification and still fires
    clear_stats();
    btn = 1'b1; c0 = cyc;
    tick(11 + 45);
    btn = 1'b0;
    tick(20);
    chk_int("t5_repeat_count", st_rpt_n, 4);
    for (int i = 0; i < 4; i++)
      chk_int("t5_repeat_offset", st_rpt_cyc[i] - st_press_cyc, 20 + 10 * i);
    chk_int("t5_release_offset", st_rel_cyc - st_press_cyc, 56);
    chk_int("t5_norepeat_count", st_b_rpt_n, 0);

    // 6: reset while held
    clear_stats();
    btn = 1'b1;
    tick(15);
    nrst = 1'b0;
    #1;
    chk_bit("t6_async_level_a", a_level, 1'b0);
    chk_bit("t6_async_level_b", b_level, 1'b0);
    tick(3);
    nrst = 1'b1; c0 = cyc;
    tick(20);
    chk_int("t6_release_count", st_rel_n, 0);
    chk_int("t6_press_count", st_press_n, 2);
    chk_int("t6_repress_latency", st_press_cyc - c0, 11);
    btn = 1'b0;
    tick(20);

    // Random run lengths around the debounce threshold, with occasional resets
    for (int seg = 0; seg < 160; seg++) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) begin
        nrst = 1'b0;
        tick($urandom_range(1, 3));
        nrst = 1'b1;
      end
      tick($urandom_range(1, 25));
    end
    btn = 1'b0;
    tick(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog cyc=%0d got=timeout want=finish", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
